fas_peak_detect: RTL
====================

# fas_peak_detect

Analysis-stage back end of the frequency analysis system: consumes the 16-point spectrum frames emitted on the FFT output interface (`fft_valid` + `fft_d0`..`fft_d15`), computes per-bin squared magnitude sequentially, and reports the dominant bin on `freq` with a one-cycle `done` strobe. It sits directly downstream of the FFT stage and is the receiving end of that frame interface.

## Interface
- `DW`, 16, width of each real/imag component (signed 8.8 fixed point); squared magnitude is `2*DW` bits unsigned
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fft_valid`  in  1  frame strobe; all 16 bin words valid this cycle
- `fft_d0`..`fft_d15`  in  2*DW each  bin k: `[2*DW-1:DW]` real, `[DW-1:0]` imag, two's complement
- `done`  out  1  one-cycle pulse; `freq` holds a new result
- `freq`  out  4  index of max-magnitude bin; held until next `done`
- `overrun`  out  1  one-cycle pulse; a frame was dropped

## Operation
- States: IDLE, SCAN. Bin counter `cnt` (4 bits), running max `mx` (2*DW bits), index `mi` (4 bits).
- IDLE: when `fft_valid`=1, register all 16 words into the frame bank, set `cnt`=first bin, `mx`=0, `mi`=first bin, go to SCAN.
- SCAN: each cycle, compute `mag = re*re + im*im` for bin `cnt` (signed multiply, unsigned 2*DW-bit sum, no overflow possible for DW=16: max 2^31). If `mag > mx` (strict), `mx<=mag`, `mi<=cnt`. Ties keep the lower index. Note `mx` init 0 means an all-zero frame reports the first bin.
- Last bin (`cnt`=15): `freq<=` final index (including a possible update this cycle), `done<=1` next cycle. If `fft_valid`=1 in this same cycle, capture the new frame and restart SCAN (back-to-back); otherwise return to IDLE.
- `fft_valid`=1 in SCAN with `cnt`<15: frame ignored, `overrun` pulses next cycle; current scan and bank unaffected.
- Frame bank only written on accepted frames.

## Timing
- Reset values: `done`=0, `overrun`=0, `freq`=0, state IDLE, `cnt`=0, `mx`=0, `mi`=0.
- Latency: `fft_valid` sampled at edge E0; bin k evaluated at edge E(k+1); `done`=1 and new `freq` visible in the cycle after E16 (17 cycles after frame strobe), both driven from registers.
- Throughput: one frame per 16 cycles; frame strobes exactly 16 cycles apart never overrun, and yield `done` every 16 cycles.
- `done` never asserts for two consecutive cycles.
- `rst` during SCAN: scan aborted, no `done` for that frame, `freq` returns to 0.
- `rst` and `fft_valid` in the same cycle: reset wins, frame dropped, no `overrun`.

## Configuration
- `FAS_PEAK_SKIP_DC_EN` defined: bin 0 excluded; scan covers bins 1..15 (15 cycles, `done` 16 cycles after frame strobe; back-to-back accept still only on last bin); `freq` never 0 except after reset.
- Not defined: all 16 bins scanned as above; `freq` may be 0.

## Test plan
- Single tone: frame with bin 5 = {0x0100, 0x0000}, others 0 -> `done` exactly 17 cycles after `fft_valid`, `freq`=5, `overrun`=0.
- Symmetric tie: bins 1 and 15 both {0x0200, 0x0000} -> `freq`=1 (lower index wins).
- Signed inputs: bin 3 = {0xFF00, 0xFE00} (mag 5·2^16), bin 9 = {0x0200, 0x0000} (mag 4·2^16) -> `freq`=3.
- Streaming: 4 frames at 16-cycle spacing, peaks at bins 2, 7, 12, 15 -> 4 `done` pulses 16 cycles apart with those `freq` values, `overrun` never 1.
- Overrun and reset: second `fft_valid` 5 cycles after first -> `overrun` pulse, first result unchanged; then `rst` at bin 8 of a new scan -> no `done`, `freq`=0.
- DC handling: bin 0 = {0x0400, 0}, bin 4 = {0x0100, 0} -> `freq`=0 without `FAS_PEAK_SKIP_DC_EN`; `freq`=4 and `done` at 16 cycles with it.

Source files
------------

// File: rtl/fas_peak_detect.sv
// fas_peak_detect: spectrum peak picker behind the FFT stage.
// Captures a 16-bin frame, scans one bin per cycle computing re^2 + im^2,
// and reports the index of the strongest bin on freq_o with a done_o pulse.
// Build option: define FAS_PEAK_SKIP_DC_EN to exclude bin 0 from the scan.
module fas_peak_detect #(
  parameter int unsigned DW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fft_valid_i,
  input  logic [2*DW-1:0] fft_d0_i,
  input  logic [2*DW-1:0] fft_d1_i,
  input  logic [2*DW-1:0] fft_d2_i,
  input  logic [2*DW-1:0] fft_d3_i,
  input  logic [2*DW-1:0] fft_d4_i,
  input  logic [2*DW-1:0] fft_d5_i,
  input  logic [2*DW-1:0] fft_d6_i,
  input  logic [2*DW-1:0] fft_d7_i,
  input  logic [2*DW-1:0] fft_d8_i,
  input  logic [2*DW-1:0] fft_d9_i,
  input  logic [2*DW-1:0] fft_d10_i,
  input  logic [2*DW-1:0] fft_d11_i,
  input  logic [2*DW-1:0] fft_d12_i,
  input  logic [2*DW-1:0] fft_d13_i,
  input  logic [2*DW-1:0] fft_d14_i,
  input  logic [2*DW-1:0] fft_d15_i,
  output logic            done_o,
  output logic [3:0]      freq_o,
  output logic            overrun_o
);

`ifdef FAS_PEAK_SKIP_DC_EN
  localparam logic [3:0] FirstBin = 4'd1;
`else
  localparam logic [3:0] FirstBin = 4'd0;
`endif
  localparam logic [3:0] LastBin = 4'd15;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2*DW-1:0] mx_q, mx_d;
  logic [3:0]      mi_q, mi_d;
  logic [3:0]      freq_q, freq_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic [2*DW-1:0] frame_in [16];
  logic [2*DW-1:0] bank_q [16];
  logic            bank_we;

  logic [2*DW-1:0]        cur_word;
  logic signed [DW-1:0]   cur_re, cur_im;
  logic signed [2*DW-1:0] re_ext, im_ext;
  logic signed [2*DW-1:0] re_sq, im_sq;
  logic [2*DW-1:0]        mag;
  logic                   is_last;
  logic                   upd;
  logic [2*DW-1:0]        mx_upd;
  logic [3:0]             mi_upd;

  // Gather the frame ports into an indexable array.
  always_comb begin
    frame_in[0]  = fft_d0_i;
    frame_in[1]  = fft_d1_i;
    frame_in[2]  = fft_d2_i;
    frame_in[3]  = fft_d3_i;
    frame_in[4]  = fft_d4_i;
    frame_in[5]  = fft_d5_i;
    frame_in[6]  = fft_d6_i;
    frame_in[7]  = fft_d7_i;
    frame_in[8]  = fft_d8_i;
    frame_in[9]  = fft_d9_i;
    frame_in[10] = fft_d10_i;
    frame_in[11] = fft_d11_i;
    frame_in[12] = fft_d12_i;
    frame_in[13] = fft_d13_i;
    frame_in[14] = fft_d14_i;
    frame_in[15] = fft_d15_i;
  end

  // Squared magnitude of the bin under the counter, plus running-max update.
  always_comb begin
    cur_word = bank_q[cnt_q];
    cur_re   = $signed(cur_word[2*DW-1:DW]);
    cur_im   = $signed(cur_word[DW-1:0]);
    re_ext   = {{DW{cur_re[DW-1]}}, cur_re};
    im_ext   = {{DW{cur_im[DW-1]}}, cur_im};
    re_sq    = re_ext * re_ext;
    im_sq    = im_ext * im_ext;
    // Each square is at most 2^(2*DW-2), so the unsigned sum cannot wrap.
    mag      = $unsigned(re_sq) + $unsigned(im_sq);
    is_last  = (cnt_q == LastBin);
    // Strict compare: on ties the earlier (lower) bin keeps the lead.
    upd      = (mag > mx_q);
    mx_upd   = upd ? mag : mx_q;
    mi_upd   = upd ? cnt_q : mi_q;
  end

  // Next-state logic for the scan controller and result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mx_d      = mx_q;
    mi_d      = mi_q;
    freq_d    = freq_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    bank_we   = 1'b0;

    case (state_q)
      StIdle: begin
        if (fft_valid_i) begin
          bank_we = 1'b1;
          cnt_d   = FirstBin;
          mx_d    = '0;
          mi_d    = FirstBin;
          state_d = StScan;
        end
      end

      StScan: begin
        mx_d = mx_upd;
        mi_d = mi_upd;
        if (is_last) begin
          freq_d = mi_upd;
          done_d = 1'b1;
          if (fft_valid_i) begin
            // Back-to-back frame: accept it on the final bin and keep scanning.
            bank_we = 1'b1;
            cnt_d   = FirstBin;
            mx_d    = '0;
            mi_d    = FirstBin;
            state_d = StScan;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          // A frame arriving mid-scan is dropped; the scan carries on.
          if (fft_valid_i) begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mx_q      <= '0;
      mi_q      <= '0;
      freq_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mx_q      <= mx_d;
      mi_q      <= mi_d;
      freq_q    <= freq_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame bank: written only when a frame is accepted (reset drops the frame).
  always_ff @(posedge clk_i) begin
    if (!rst_i && bank_we) begin
      for (int k = 0; k < 16; k++) begin
        bank_q[k] <= frame_in[k];
      end
    end
  end

  assign done_o    = done_q;
  assign freq_o    = freq_q;
  assign overrun_o = overrun_q;

endmodule
